rf_scoreboard: RTL and testbench

Parametrised register file with a per-register scoreboard for the crypto processor datapath. It has two combinational read ports and two write ports. Port A is the single-cycle pipeline writeback. Port B is the long-latency crypto-unit writeback. Destinations of multi-cycle crypto operations are reserved at issue and released on port-B writeback, so issue logic can stall on RAW and WAW hazards. Register 0 is hardwired to zero and never busy.

---
 rtl/rf_scoreboard.sv | 143 ++++++++++++++
 tb/tb_rf_scoreboard.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Register file with a per-register scoreboard for the crypto datapath.
//   Two combinational read ports, a single-cycle writeback port (A) and a
//   long-latency crypto writeback port (B). Destinations of multi-cycle
//   operations are reserved at issue and released by a port-B write, so
//   issue logic can stall on RAW/WAW hazards. Register 0 reads as zero and
//   is never busy.
//
//   Build option: define RF_BYPASS_EN to forward same-cycle writes to the
//   read ports (port B over port A). State updates are identical in both
//   builds.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rd_addr_a/b             read addresses
//   o_rd_data_a/b             read data
//   o_rd_busy_a/b             addressed register has a pending reservation
//   i_wa_en/addr/data         port A (pipeline) write
//   i_wb_en/addr/data         port B (crypto) write, releases a reservation
//   i_rsv_en/addr             reserve a destination register
//   o_rsv_ok                  reservation at i_rsv_addr would be accepted
//   o_busy_count              number of busy registers
//   o_err                     sticky protocol-violation flag
module rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_rd_busy_a,
  output logic              o_rd_busy_b,
  input  logic              i_wa_en,
  input  logic [ADDR_W-1:0] i_wa_addr,
  input  logic [DATA_W-1:0] i_wa_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic              o_rsv_ok,
  output logic [ADDR_W-1:0] o_busy_count,
  output logic              o_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W-1:0]   r_busy_count;
  logic                r_err;

  logic w_wa_hit, w_wa_valid;
  logic w_wb_hit, w_wb_valid;
  logic w_rsv_ok, w_rsv_set;
  logic w_err_set;

  // Both write ports judge against the pre-edge busy bit. On a same-address
  // collision exactly one of them is valid: A if the register is free, B if
  // it is busy.
  assign w_wa_hit   = i_wa_en && (i_wa_addr != '0);
  assign w_wa_valid = w_wa_hit && !r_busy[i_wa_addr];
  assign w_wb_hit   = i_wb_en && (i_wb_addr != '0);
  assign w_wb_valid = w_wb_hit && r_busy[i_wb_addr];

  // A register being released this cycle may be re-reserved immediately.
  assign w_rsv_ok  = (i_rsv_addr == '0) || !r_busy[i_rsv_addr] ||
                     (w_wb_valid && (i_wb_addr == i_rsv_addr));
  assign w_rsv_set = i_rsv_en && w_rsv_ok && (i_rsv_addr != '0);

  assign w_err_set = (w_wa_hit && !w_wa_valid) ||
                     (w_wb_hit && !w_wb_valid) ||
                     (i_rsv_en && !w_rsv_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy       <= '0;
      r_busy_count <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_wa_valid) begin
        r_regs[i_wa_addr] <= i_wa_data;
      end
      if (w_wb_valid) begin
        r_regs[i_wb_addr] <= i_wb_data;
        r_busy[i_wb_addr] <= 1'b0;
      end
      // Placed after the release so a same-cycle re-reserve leaves it busy.
      if (w_rsv_set) begin
        r_busy[i_rsv_addr] <= 1'b1;
      end
      r_busy_count <= r_busy_count + ADDR_W'(w_rsv_set) - ADDR_W'(w_wb_valid);
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    o_rd_data_a = '0;
    o_rd_busy_a = 1'b0;
    if (i_rd_addr_a != '0) begin
      o_rd_data_a = r_regs[i_rd_addr_a];
      o_rd_busy_a = r_busy[i_rd_addr_a];
`ifdef RF_BYPASS_EN
      if (w_wb_valid && (i_wb_addr == i_rd_addr_a)) begin
        o_rd_data_a = i_wb_data;
        o_rd_busy_a = 1'b0;
      end else if (w_wa_valid && (i_wa_addr == i_rd_addr_a)) begin
        o_rd_data_a = i_wa_data;
      end
`endif
    end
  end

  always_comb begin
    o_rd_data_b = '0;
    o_rd_busy_b = 1'b0;
    if (i_rd_addr_b != '0) begin
      o_rd_data_b = r_regs[i_rd_addr_b];
      o_rd_busy_b = r_busy[i_rd_addr_b];
`ifdef RF_BYPASS_EN
      if (w_wb_valid && (i_wb_addr == i_rd_addr_b)) begin
        o_rd_data_b = i_wb_data;
        o_rd_busy_b = 1'b0;
      end else if (w_wa_valid && (i_wa_addr == i_rd_addr_b)) begin
        o_rd_data_b = i_wa_data;
      end
`endif
    end
  end

  assign o_rsv_ok     = w_rsv_ok;
  assign o_busy_count = r_busy_count;
  assign o_err        = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_busy_a, rd_busy_b;
  logic          wa_en, wb_en, rsv_en;
  logic [AW-1:0] wa_addr, wb_addr, rsv_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic          rsv_ok;
  logic [AW-1:0] busy_count;
  logic          err;

  always #5 clk = ~clk;

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b),
    .o_rd_data_a(rd_data_a), .o_rd_data_b(rd_data_b),
    .o_rd_busy_a(rd_busy_a), .o_rd_busy_b(rd_busy_b),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_rsv_ok(rsv_ok),
    .o_busy_count(busy_count), .o_err(err)
  );

  typedef struct {
    int unsigned rst, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data;
    int unsigned rsv_en, rsv_addr, ra, rb;
    int unsigned e_da, e_ba, e_db, e_bb, e_ok, e_cnt, e_err;
  } vec_t;

  typedef struct {
    int unsigned cnt;
    int unsigned err;
    string       tag;
  } exp_t;

  vec_t vecs[25];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst[0];
    wa_en     = v.wa_en[0];
    wa_addr   = AW'(v.wa_addr);
    wa_data   = DW'(v.wa_data);
    wb_en     = v.wb_en[0];
    wb_addr   = AW'(v.wb_addr);
    wb_data   = DW'(v.wb_data);
    rsv_en    = v.rsv_en[0];
    rsv_addr  = AW'(v.rsv_addr);
    rd_addr_a = AW'(v.ra);
    rd_addr_b = AW'(v.rb);
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0};
    return v;
  endfunction

  // Expected registered state goes into the scoreboard when the cycle is
  // driven and is compared once the DUT has taken the edge.
  task automatic finish_cycle(input string tag, input int unsigned e_cnt, input int unsigned e_err);
    exp_t e;
    sb.push_back('{e_cnt, e_err, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, " busy_count"}, 32'(busy_count), e.cnt);
    check({e.tag, " err"}, 32'(err), e.err);
  endtask

  initial begin
    vec_t v;
    string t;

    //         rst wa a  data     wb a  data     rv ra  rA rB  da      ba db      bb ok cnt err
    vecs[0]  = '{1, 1, 3, 'hDEAD,  0, 0, 0,       1, 4,  1, 4,  0,      0, 0,      0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,       0, 0, 0,       0, 0,  3, 4,  0,      0, 0,      0, 1, 0, 0};
    vecs[2]  = '{0, 1, 3, 'h1111,  0, 0, 0,       1, 5,  5, 6,  0,      0, 0,      0, 1, 1, 0};
    vecs[3]  = '{0, 0, 0, 0,       0, 0, 0,       0, 5,  5, 3,  0,      1, 'h1111, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 0, 0,       1, 5, 'h1234,  0, 5,  6, 3,  0,      0, 'h1111, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0,       0, 0, 0,       1, 7,  5, 7,  'h1234, 0, 0,      0, 1, 1, 0};
    vecs[6]  = '{0, 0, 0, 0,       0, 0, 0,       1, 9,  7, 9,  0,      1, 0,      0, 1, 2, 0};
    vecs[7]  = '{0, 1, 7, 'hAAAA,  0, 0, 0,       0, 0,  9, 2,  0,      1, 0,      0, 1, 2, 1};
    vecs[8]  = '{0, 0, 0, 0,       0, 0, 0,       1, 7,  7, 9,  0,      1, 0,      1, 0, 2, 1};
    vecs[9]  = '{1, 0, 0, 0,       0, 0, 0,       0, 0,  7, 9,  0,      1, 0,      1, 1, 0, 0};
    vecs[10] = '{0, 1, 8, 'h88,    0, 0, 0,       1, 9,  9, 7,  0,      0, 0,      0, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 0,       1, 9, 'h55,    1, 9,  8, 7,  'h88,   0, 0,      0, 1, 1, 0};
    vecs[12] = '{0, 0, 0, 0,       0, 0, 0,       0, 9,  9, 0,  'h55,   1, 0,      0, 0, 1, 0};
    vecs[13] = '{0, 1, 0, 'hFFFF,  1, 0, 'hEEEE,  1, 0,  0, 0,  0,      0, 0,      0, 1, 1, 0};
    vecs[14] = '{0, 0, 0, 0,       0, 0, 0,       0, 0,  0, 9,  0,      0, 'h55,   1, 1, 1, 0};
    vecs[15] = '{0, 1, 10,'hA0,    0, 0, 0,       1, 10, 9, 1,  'h55,   1, 0,      0, 1, 2, 0};
    vecs[16] = '{0, 0, 0, 0,       0, 0, 0,       0, 10, 10,10, 'hA0,   1, 'hA0,   1, 0, 2, 0};
    vecs[17] = '{0, 1, 10,'h11,    1, 10,'h22,    0, 0,  9, 1,  'h55,   1, 0,      0, 1, 1, 1};
    vecs[18] = '{0, 0, 0, 0,       0, 0, 0,       0, 0,  10,9,  'h22,   0, 'h55,   1, 1, 1, 1};
    vecs[19] = '{1, 0, 0, 0,       0, 0, 0,       0, 0,  10,1,  'h22,   0, 0,      0, 1, 0, 0};
    vecs[20] = '{0, 1, 10,'h33,    1, 10,'h44,    0, 0,  1, 2,  0,      0, 0,      0, 1, 0, 1};
    vecs[21] = '{0, 0, 0, 0,       0, 0, 0,       0, 0,  10,1,  'h33,   0, 0,      0, 1, 0, 1};
    vecs[22] = '{1, 0, 0, 0,       0, 0, 0,       0, 0,  10,1,  'h33,   0, 0,      0, 1, 0, 0};
    vecs[23] = '{0, 0, 0, 0,       1, 4, 'h99,    0, 0,  10,4,  0,      0, 0,      0, 1, 0, 1};
    vecs[24] = '{0, 0, 0, 0,       0, 0, 0,       0, 0,  10,4,  0,      0, 0,      0, 1, 0, 1};

    v = idle_vec();
    v.rst = 1;
    drive(v);
    repeat (2) @(posedge clk);

    // Table-driven directed vectors.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      t = $sformatf("v%0d", i);
      check({t, " rd_data_a"}, rd_data_a, vecs[i].e_da);
      check({t, " rd_busy_a"}, 32'(rd_busy_a), vecs[i].e_ba);
      check({t, " rd_data_b"}, rd_data_b, vecs[i].e_db);
      check({t, " rd_busy_b"}, 32'(rd_busy_b), vecs[i].e_bb);
      check({t, " rsv_ok"}, 32'(rsv_ok), vecs[i].e_ok);
      finish_cycle(t, vecs[i].e_cnt, vecs[i].e_err);
    end

    // Fill every reservable register, then release them all.
    @(negedge clk);
    v = idle_vec();
    v.rst = 1;
    drive(v);
    finish_cycle("fill_rst", 0, 0);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      v = idle_vec();
      v.rsv_en = 1; v.rsv_addr = i; v.ra = i;
      drive(v);
      #1;
      t = $sformatf("fill%0d", i);
      check({t, " rsv_ok"}, 32'(rsv_ok), 1);
      check({t, " rd_busy_a"}, 32'(rd_busy_a), 0);
      finish_cycle(t, i, 0);
    end
    @(negedge clk);
    v = idle_vec();
    v.rsv_addr = 31; v.ra = 31;
    drive(v);
    #1;
    check("full rsv_ok", 32'(rsv_ok), 0);
    check("full rd_busy_a", 32'(rd_busy_a), 1);
    finish_cycle("full", 31, 0);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      v = idle_vec();
      v.wb_en = 1; v.wb_addr = i; v.wb_data = 'h100 + i; v.ra = i - 1;
      drive(v);
      #1;
      t = $sformatf("drain%0d", i);
      check({t, " rd_data_a"}, rd_data_a, (i == 1) ? 0 : 'h100 + i - 1);
      check({t, " rd_busy_a"}, 32'(rd_busy_a), 0);
      finish_cycle(t, 31 - i, 0);
    end

    // Same-cycle forwarding corner: read a register while it is written.
    @(negedge clk);
    v = idle_vec();
    v.rst = 1;
    drive(v);
    finish_cycle("byp_rst", 0, 0);
    @(negedge clk);
    v = idle_vec();
    v.wa_en = 1; v.wa_addr = 2; v.wa_data = 'h77;
    drive(v);
    finish_cycle("byp_wa2", 0, 0);
    @(negedge clk);
    v = idle_vec();
    v.rsv_en = 1; v.rsv_addr = 2;
    drive(v);
    finish_cycle("byp_rsv2", 1, 0);
    @(negedge clk);
    v = idle_vec();
    v.wb_en = 1; v.wb_addr = 2; v.wb_data = 'hBEEF;
    v.wa_en = 1; v.wa_addr = 3; v.wa_data = 'h99;
    v.ra = 2; v.rb = 3;
    drive(v);
    #1;
`ifdef RF_BYPASS_EN
    check("byp rd_data_a", rd_data_a, 'hBEEF);
    check("byp rd_busy_a", 32'(rd_busy_a), 0);
    check("byp rd_data_b", rd_data_b, 'h99);
`else
    check("byp rd_data_a", rd_data_a, 'h77);
    check("byp rd_busy_a", 32'(rd_busy_a), 1);
    check("byp rd_data_b", rd_data_b, 0);
`endif
    check("byp rd_busy_b", 32'(rd_busy_b), 0);
    finish_cycle("byp_wb2", 0, 0);
    @(negedge clk);
    v = idle_vec();
    v.ra = 2; v.rb = 3;
    drive(v);
    #1;
    check("post rd_data_a", rd_data_a, 'hBEEF);
    check("post rd_busy_a", 32'(rd_busy_a), 0);
    check("post rd_data_b", rd_data_b, 'h99);
    finish_cycle("post", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
